// File: rtl/store_merge_lsu.sv
// Load/store unit in front of a word-wide, single-write-enable data RAM.
// Sub-word stores run as a two-cycle read-modify-write; illegal accesses are blocked and logged.
module store_merge_lsu #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic        fault,
  output logic [31:0] fault_address,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [0:0] {StIdle, StRmwWrite} state_e;

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q;
  logic [31:0] fault_addr_q;

  logic        is_byte, is_half, is_word;
  logic        is_store, is_load;
  logic        illegal, access_fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merge_word;
  logic [31:0] word_addr;

  // Access decode, lane extraction and merge are independent of state.
  always_comb begin
    is_byte   = (cpu_size == 2'b00);
    is_half   = (cpu_size == 2'b01);
    is_word   = cpu_size[1];
    // A simultaneous read and write is handled as a store.
    is_store  = cpu_mem_write;
    is_load   = cpu_mem_read & ~cpu_mem_write;
    illegal   = (is_half & cpu_address[0]) | (is_word & (|cpu_address[1:0])) |
                (cpu_address > ADDR_LIMIT);
    word_addr = {cpu_address[31:2], 2'b00};

    byte_lane = mem_read_data[{cpu_address[1:0], 3'b000} +: 8];
    half_lane = cpu_address[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    if (is_byte) begin
      load_ext = {{24{~cpu_unsigned & byte_lane[7]}}, byte_lane};
    end else if (is_half) begin
      load_ext = {{16{~cpu_unsigned & half_lane[15]}}, half_lane};
    end else begin
      load_ext = mem_read_data;
    end

    merge_word = mem_read_data;
    if (is_byte) begin
      merge_word[{cpu_address[1:0], 3'b000} +: 8] = cpu_write_data[7:0];
    end else begin
      merge_word[{cpu_address[1], 4'b0000} +: 16] = cpu_write_data[15:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    merge_d        = merge_q;
    addr_d         = addr_q;
    stall          = 1'b0;
    mem_write      = 1'b0;
    mem_address    = word_addr;
    mem_write_data = cpu_write_data;
    cpu_read_data  = 32'h0;
    access_fault   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((is_store | is_load) && illegal) begin
          access_fault = 1'b1;
        end else if (is_store) begin
          if (is_word) begin
            mem_write = 1'b1;
          end else begin
            stall   = 1'b1;
            merge_d = merge_word;
            addr_d  = word_addr;
            state_d = StRmwWrite;
          end
        end else if (is_load) begin
          cpu_read_data = load_ext;
        end
      end
      StRmwWrite: begin
        // CPU inputs still show the held store here; they are deliberately ignored.
        mem_write      = ~reset;
        mem_address    = addr_q;
        mem_write_data = merge_q;
        state_d        = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      merge_q      <= 32'h0;
      addr_q       <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
      if (access_fault) begin
        fault_q <= 1'b1;
        if (!fault_q) begin
          fault_addr_q <= cpu_address;
        end
      end
    end
  end

  assign fault         = fault_q;
  assign fault_address = fault_addr_q;

endmodule

// File: tb/tb_store_merge_lsu.sv
// Self-checking bench for store_merge_lsu: directed scenarios plus randomized traffic
// checked against a byte-addressed memory model.
module tb_store_merge_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_mem_read, cpu_mem_write, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        stall, fault, mem_write;
  logic [31:0] fault_address, mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  store_merge_lsu #(.ADDR_LIMIT(32'h0000_FFFF)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_size      (cpu_size),
    .cpu_unsigned  (cpu_unsigned),
    .cpu_address   (cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data (cpu_read_data),
    .stall         (stall),
    .fault         (fault),
    .fault_address (fault_address),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  always #5 clock = ~clock;

  // RAM stand-in: 4 KiB, combinational read, write on negedge.
  logic [31:0] ram [0:1023];
  int          wr_count = 0;
  assign mem_read_data = ram[mem_address[11:2]];
  always @(negedge clock) begin
    if (mem_write) begin
      ram[mem_address[11:2]] <= mem_write_data;
      wr_count               <= wr_count + 1;
    end
  end

  // Reference model: plain byte array, little-endian.
  logic [7:0] mb [0:4095];

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [11:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = mb[a];
    b1 = mb[a + 12'd1];
    b2 = mb[a + 12'd2];
    b3 = mb[a + 12'd3];
    if (sz == 2'b00) return {{24{~uns & b0[7]}}, b0};
    if (sz == 2'b01) return {{16{~uns & b1[7]}}, b1, b0};
    return {b3, b2, b1, b0};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[a + 12'(i)] = d[8*i +: 8];
  endtask

  task automatic preload_word(input logic [31:0] a, input logic [31:0] v);
    ram[a[11:2]] <= v;
    for (int i = 0; i < 4; i++) mb[{a[11:2], 2'b00} + 12'(i)] = v[8*i +: 8];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #6;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    cpu_mem_read   = rd;
    cpu_mem_write  = wr;
    cpu_size       = sz;
    cpu_unsigned   = uns;
    cpu_address    = a;
    cpu_write_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (fault_address !== 32'h0) begin errors++; $display("FAIL reset_fault_address got %h want 0", fault_address); end
    checks++; if (cpu_read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", cpu_read_data); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_load_word();
    preload_word(32'h10, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    settle();
    checks++; if (cpu_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_word got %h want deadbeef", cpu_read_data); end
    checks++; if (stall !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL load_word_flags got stall=%b fault=%b want 0 0", stall, fault); end
    checks++; if (mem_address !== 32'h10) begin errors++; $display("FAIL load_word_addr got %h want 10", mem_address); end
  endtask

  task automatic test_load_ext();
    tick();
    preload_word(32'h10, 32'h80FF_0000);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    settle();
    checks++; if (cpu_read_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_sbyte got %h want ffffff80", cpu_read_data); end
    tick();
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    settle();
    checks++; if (cpu_read_data !== 32'h0000_0080) begin errors++; $display("FAIL load_ubyte got %h want 00000080", cpu_read_data); end
    tick();
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    settle();
    checks++; if (cpu_read_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL load_shalf got %h want ffff80ff", cpu_read_data); end
    tick();
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    settle();
    checks++; if (cpu_read_data !== 32'h0000_0000) begin errors++; $display("FAIL load_uhalf_lo got %h want 0", cpu_read_data); end
  endtask

  task automatic test_byte_store();
    int wc0;
    tick();
    preload_word(32'h20, 32'h1122_3344);
    wc0 = wr_count;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h5A5A_5AAB);
    settle();
    checks++; if (stall !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL bstore_c1 got stall=%b wr=%b want 1 0", stall, mem_write); end
    tick();
    settle();
    checks++; if (mem_write !== 1'b1 || mem_write_data !== 32'h1122_AB44) begin errors++; $display("FAIL bstore_c2_data got wr=%b data=%h want 1 1122ab44", mem_write, mem_write_data); end
    checks++; if (mem_address !== 32'h20 || stall !== 1'b0) begin errors++; $display("FAIL bstore_c2_addr got addr=%h stall=%b want 20 0", mem_address, stall); end
    model_store(2'b00, 12'h21, 32'h5A5A_5AAB);
    tick();
    idle();
    settle();
    checks++; if (mem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL bstore_idle got wr=%b stall=%b want 0 0", mem_write, stall); end
    checks++; if (ram[8] !== 32'h1122_AB44 || wr_count - wc0 !== 1) begin errors++; $display("FAIL bstore_ram got %h writes=%0d want 1122ab44 1", ram[8], wr_count - wc0); end
  endtask

  task automatic test_back_to_back();
    int wc0;
    tick();
    preload_word(32'h100, 32'hCAFE_F00D);
    wc0 = wr_count;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_5566);
    settle();
    checks++; if (stall !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL b2b_half_c1 got stall=%b wr=%b want 1 0", stall, mem_write); end
    tick();
    settle();
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'h100 || mem_write_data !== 32'h5566_F00D) begin errors++; $display("FAIL b2b_half_c2 got wr=%b addr=%h data=%h want 1 100 5566f00d", mem_write, mem_address, mem_write_data); end
    model_store(2'b01, 12'h102, 32'h0000_5566);
    tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h1234_5678);
    settle();
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'h104 || mem_write_data !== 32'h1234_5678 || stall !== 1'b0) begin errors++; $display("FAIL b2b_word got wr=%b addr=%h data=%h stall=%b want 1 104 12345678 0", mem_write, mem_address, mem_write_data, stall); end
    model_store(2'b10, 12'h104, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h105, 32'h0000_0099);
    settle();
    checks++; if (stall !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL b2b_byte_c1 got stall=%b wr=%b want 1 0", stall, mem_write); end
    tick();
    settle();
    checks++; if (mem_write_data !== 32'h1234_9978 || mem_address !== 32'h104) begin errors++; $display("FAIL b2b_byte_c2 got addr=%h data=%h want 104 12349978", mem_address, mem_write_data); end
    model_store(2'b00, 12'h105, 32'h0000_0099);
    tick();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h0000_BEEF);
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_half2_c1 got stall=%b want 1", stall); end
    tick();
    settle();
    checks++; if (mem_write_data !== 32'hBEEF_9978) begin errors++; $display("FAIL b2b_half2_c2 got %h want beef9978", mem_write_data); end
    model_store(2'b01, 12'h106, 32'h0000_BEEF);
    tick();
    idle();
    settle();
    checks++; if (wr_count - wc0 !== 4 || ram[64] !== 32'h5566_F00D || ram[65] !== 32'hBEEF_9978) begin errors++; $display("FAIL b2b_ram got writes=%0d w100=%h w104=%h want 4 5566f00d beef9978", wr_count - wc0, ram[64], ram[65]); end
  endtask

  task automatic test_random();
    int          wc0, stores, bad;
    logic [1:0]  sz;
    logic [31:0] a, d, exp;
    logic        uns, both;
    bool_loop: for (int n = 0; n < 300; n++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, 4095));
      d   = $urandom;
      uns = 1'($urandom_range(0, 1));
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      both = ($urandom_range(0, 3) == 0);
      tick();
      if (n == 0) begin
        wc0    = wr_count;
        stores = 0;
      end
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b1, 1'b0, sz, uns, a, d);
        settle();
        exp = model_load(sz, uns, a[11:0]);
        checks++; if (cpu_read_data !== exp || mem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rnd_load a=%h sz=%0d got %h wr=%b stall=%b want %h 0 0", a, sz, cpu_read_data, mem_write, stall, exp); end
      end else begin
        drive(both, 1'b1, sz, uns, a, d);
        stores++;
        model_store(sz, a[11:0], d);
        exp = model_load(2'b10, 1'b0, {a[11:2], 2'b00});
        settle();
        if (!sz[1]) begin
          checks++; if (stall !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rnd_sub_c1 a=%h got stall=%b wr=%b want 1 0", a, stall, mem_write); end
          tick();
          settle();
        end
        checks++; if (mem_write !== 1'b1 || mem_write_data !== exp || mem_address !== {a[31:2], 2'b00} || stall !== 1'b0) begin errors++; $display("FAIL rnd_store a=%h sz=%0d got wr=%b addr=%h data=%h want 1 %h %h", a, sz, mem_write, mem_address, mem_write_data, {a[31:2], 2'b00}, exp); end
      end
      if ($urandom_range(0, 4) == 0) begin
        tick();
        idle();
        settle();
        checks++; if (cpu_read_data !== 32'h0 || mem_write !== 1'b0) begin errors++; $display("FAIL rnd_idle got rd=%h wr=%b want 0 0", cpu_read_data, mem_write); end
      end
    end
    tick();
    idle();
    settle();
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ram[i] !== {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]}) bad++;
    end
    checks++; if (bad != 0 || wr_count - wc0 != stores) begin errors++; $display("FAIL rnd_ram got bad_words=%0d writes=%0d want 0 %0d", bad, wr_count - wc0, stores); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rnd_no_fault got %b want 0", fault); end
  endtask

  task automatic test_fault();
    logic [31:0] exp, saved;
    tick();
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_FFFF, 32'h0);
    settle();
    exp = model_load(2'b00, 1'b1, 12'hFFF);
    checks++; if (cpu_read_data !== exp) begin errors++; $display("FAIL limit_load got %h want %h", cpu_read_data, exp); end
    tick();
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0);
    settle();
    checks++; if (mem_write !== 1'b0 || cpu_read_data !== 32'h0 || stall !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL fault_half_c1 got wr=%b rd=%h stall=%b fault=%b want 0 0 0 0", mem_write, cpu_read_data, stall, fault); end
    tick();
    saved = ram[0];
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'h7777_7777);
    settle();
    checks++; if (fault !== 1'b1 || fault_address !== 32'h31) begin errors++; $display("FAIL fault_first got fault=%b addr=%h want 1 31", fault, fault_address); end
    checks++; if (mem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL fault_range_store got wr=%b stall=%b want 0 0", mem_write, stall); end
    tick();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0001_0001, 32'h66);
    settle();
    checks++; if (stall !== 1'b0 || mem_write !== 1'b0 || fault_address !== 32'h31) begin errors++; $display("FAIL fault_range_byte got stall=%b wr=%b addr=%h want 0 0 31", stall, mem_write, fault_address); end
    tick();
    drive(1'b0, 1'b1, 2'b11, 1'b0, 32'h22, 32'h5555_5555);
    settle();
    checks++; if (mem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL fault_misaligned_word got wr=%b stall=%b want 0 0", mem_write, stall); end
    tick();
    idle();
    settle();
    checks++; if (fault_address !== 32'h31 || fault !== 1'b1 || ram[0] !== saved || ram[8] !== 32'h1122_AB44) begin errors++; $display("FAIL fault_sticky got fault=%b addr=%h want 1 31 with RAM unchanged", fault, fault_address); end
  endtask

  task automatic test_reset_rmw();
    int wc0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    preload_word(32'h40, 32'h1122_3344);
    settle();
    checks++; if (fault !== 1'b0 || fault_address !== 32'h0) begin errors++; $display("FAIL rst_clears_fault got fault=%b addr=%h want 0 0", fault, fault_address); end
    tick();
    wc0 = wr_count;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h42, 32'hEE);
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_rmw_c1 got stall=%b want 1", stall); end
    tick();
    reset = 1'b1;
    settle();
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_rmw_write got wr=%b want 0", mem_write); end
    tick();
    reset = 1'b0;
    idle();
    settle();
    checks++; if (stall !== 1'b0 || mem_write !== 1'b0 || fault !== 1'b0 || wr_count != wc0 || ram[16] !== 32'h1122_3344) begin errors++; $display("FAIL rst_rmw_after got stall=%b wr=%b fault=%b word=%h want 0 0 0 11223344", stall, mem_write, fault, ram[16]); end
    tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    settle();
    checks++; if (cpu_read_data !== 32'h1122_3344) begin errors++; $display("FAIL rst_rmw_idle_load got %h want 11223344", cpu_read_data); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    idle();
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      preload_word(32'(i * 4), w);
    end
    test_reset();
    test_load_word();
    test_load_ext();
    test_byte_store();
    test_back_to_back();
    test_random();
    test_fault();
    test_reset_rmw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
